// File: rtl/gpio_debounce_if.sv
// GPIO conditioning interface: raw pad/configuration inputs and conditioned outputs.
interface gpio_debounce_if #(
  parameter int NUM_BITS  = 32,
  parameter int CNT_WIDTH = 8,
  parameter int PRE_WIDTH = 16
);
  logic [NUM_BITS-1:0]  gpio_raw;
  logic [NUM_BITS-1:0]  deb_en;
  logic [PRE_WIDTH-1:0] prescale;
  logic [CNT_WIDTH-1:0] threshold;
  logic [NUM_BITS-1:0]  gpio_sync;
  logic [NUM_BITS-1:0]  gpio_filt;
  logic [NUM_BITS-1:0]  rise;
  logic [NUM_BITS-1:0]  fall;
  logic                 tick;

  // Master drives the pads and configuration, and observes the conditioned levels.
  modport master (
    output gpio_raw, deb_en, prescale, threshold,
    input  gpio_sync, gpio_filt, rise, fall, tick
  );

  // Slave is the conditioning stage itself.
  modport slave (
    input  gpio_raw, deb_en, prescale, threshold,
    output gpio_sync, gpio_filt, rise, fall, tick
  );
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin GPIO input conditioning: 2-FF synchroniser, optional debounce
// driven by a shared prescaled tick, and single-cycle rise/fall pulses.
module gpio_debounce #(
  parameter int NUM_BITS  = 32,
  parameter int CNT_WIDTH = 8,
  parameter int PRE_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  gpio_debounce_if.slave bus
);

  logic [NUM_BITS-1:0]  sync1_q, sync1_d;
  logic [NUM_BITS-1:0]  sync2_q, sync2_d;
  logic [NUM_BITS-1:0]  filt_q, filt_d;
  logic [NUM_BITS-1:0]  filt_prev_q, filt_prev_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_BITS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_BITS];
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                 tick;
  logic [CNT_WIDTH:0]   eff_thr;

  // Free-running prescaler; >= lets a lowered prescale wrap immediately instead of stalling.
  always_comb begin
    tick      = (pre_cnt_q >= bus.prescale);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
  end

  // Per-bit synchroniser, bypass/debounce selection and edge-history next state.
  always_comb begin
    eff_thr     = (bus.threshold == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, bus.threshold};
    sync1_d     = bus.gpio_raw;
    sync2_d     = sync1_q;
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    for (int b = 0; b < NUM_BITS; b++) begin
      cnt_d[b] = cnt_q[b];
      if (!bus.deb_en[b]) begin
        filt_d[b] = sync2_q[b];
        cnt_d[b]  = '0;
      end else if (sync2_q[b] == filt_q[b]) begin
        cnt_d[b]  = '0;
      end else if (tick) begin
        if (({1'b0, cnt_q[b]} + (CNT_WIDTH+1)'(1)) >= eff_thr) begin
          filt_d[b] = sync2_q[b];
          cnt_d[b]  = '0;
        end else begin
          cnt_d[b]  = cnt_q[b] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset discards all sync, filter and counting progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      pre_cnt_q   <= '0;
      for (int b = 0; b < NUM_BITS; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      pre_cnt_q   <= pre_cnt_d;
      for (int b = 0; b < NUM_BITS; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign bus.gpio_sync = sync2_q;
  assign bus.gpio_filt = filt_q;
  assign bus.rise      = filt_q & ~filt_prev_q;
  assign bus.fall      = ~filt_q & filt_prev_q;
  assign bus.tick      = tick;

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: a behavioural model predicts each
// cycle's outputs, and a monitor compares them against the DUT.
module tb_gpio_debounce;

  localparam int NB = 32;

  typedef struct {
    logic [NB-1:0] sync;
    logic [NB-1:0] filt;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic          tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  gpio_debounce_if #(.NUM_BITS(NB), .CNT_WIDTH(8), .PRE_WIDTH(16)) bus ();

  gpio_debounce #(.NUM_BITS(NB), .CNT_WIDTH(8), .PRE_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // current stimulus
  logic          cur_rst;
  logic [NB-1:0] cur_raw, cur_en;
  int            cur_pre, cur_thr;

  // behavioural reference state
  logic [NB-1:0] m_seen1, m_seen2, m_level, m_last;
  int            m_since_tick;
  int            m_stable[NB];

  task automatic checkOutput(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the reference: a pin's accepted level changes only after
  // it has disagreed with the synchronised pad for eff_thr consecutive ticks.
  task automatic modelStep();
    bit tk;
    int need;
    logic [NB-1:0] nxt;
    if (cur_rst) begin
      m_seen1 = '0; m_seen2 = '0; m_level = '0; m_last = '0; m_since_tick = 0;
      for (int b = 0; b < NB; b++) m_stable[b] = 0;
      return;
    end
    tk   = (m_since_tick >= cur_pre);
    need = (cur_thr == 0) ? 1 : cur_thr;
    nxt  = m_level;
    for (int b = 0; b < NB; b++) begin
      if (!cur_en[b]) begin
        nxt[b] = m_seen2[b];
        m_stable[b] = 0;
      end else if (m_seen2[b] == m_level[b]) begin
        m_stable[b] = 0;
      end else if (tk) begin
        m_stable[b] = m_stable[b] + 1;
        if (m_stable[b] >= need) begin
          nxt[b] = m_seen2[b];
          m_stable[b] = 0;
        end
      end
    end
    m_since_tick = tk ? 0 : m_since_tick + 1;
    m_last  = m_level;
    m_level = nxt;
    m_seen2 = m_seen1;
    m_seen1 = cur_raw;
  endtask

  // Drive the current stimulus for n cycles, queuing the expected result of each edge.
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset         = cur_rst;
      bus.gpio_raw  = cur_raw;
      bus.deb_en    = cur_en;
      bus.prescale  = 16'(cur_pre);
      bus.threshold = 8'(cur_thr);
      modelStep();
      e.sync = m_seen2;
      e.filt = m_level;
      e.rise = m_level & ~m_last;
      e.fall = ~m_level & m_last;
      e.tick = (m_since_tick >= cur_pre);
      sb.push_back(e);
    end
  endtask

  // Monitor: after every active edge, compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("gpio_sync", bus.gpio_sync, e.sync);
        checkOutput("gpio_filt", bus.gpio_filt, e.filt);
        checkOutput("rise", bus.rise, e.rise);
        checkOutput("fall", bus.fall, e.fall);
        checkOutput("tick", {31'b0, bus.tick}, {31'b0, e.tick});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cur_rst = 1'b1; cur_raw = '1; cur_en = '0; cur_pre = 3; cur_thr = 0;
    reset = 1'b1; bus.gpio_raw = '1; bus.deb_en = '0; bus.prescale = 16'd3; bus.threshold = 8'd0;
    m_seen1 = '0; m_seen2 = '0; m_level = '0; m_last = '0; m_since_tick = 0;
    for (int b = 0; b < NB; b++) m_stable[b] = 0;

    $display("[TB] reset and bypass");
    applyStimulus(3);
    cur_rst = 1'b0;
    applyStimulus(6);

    $display("[TB] debounce accept");
    cur_rst = 1'b1; cur_raw = '0; applyStimulus(2);
    cur_rst = 1'b0; cur_en = 32'h1; cur_pre = 3; cur_thr = 4;
    applyStimulus(8);
    cur_raw[0] = 1'b1; applyStimulus(30);

    $display("[TB] bounce reject");
    cur_rst = 1'b1; cur_raw = '0; applyStimulus(2);
    cur_rst = 1'b0;
    cur_raw[0] = 1'b1; applyStimulus(10);
    cur_raw[0] = 1'b0; applyStimulus(2);
    cur_raw[0] = 1'b1; applyStimulus(10);
    cur_raw[0] = 1'b0; applyStimulus(12);

    $display("[TB] threshold 0 and 1 with prescale 0");
    cur_en = '1; cur_pre = 0;
    for (int t = 0; t < 2; t++) begin
      cur_thr = t;
      for (int k = 0; k < 4; k++) begin
        cur_raw[5] = ~cur_raw[5];
        applyStimulus(5);
      end
    end

    $display("[TB] mid-operation changes");
    cur_pre = 100; cur_thr = 4; cur_raw = '0; applyStimulus(5);
    cur_raw[3] = 1'b1; cur_raw[0] = 1'b1; applyStimulus(150);
    cur_raw[0] = 1'b0; applyStimulus(40);
    cur_pre = 2; applyStimulus(4);
    cur_raw[3] = ~cur_raw[3]; applyStimulus(7);
    cur_en[3] = 1'b0; applyStimulus(4);
    cur_en[3] = 1'b1; cur_raw[3] = ~cur_raw[3]; applyStimulus(4);
    cur_rst = 1'b1; applyStimulus(1);
    cur_rst = 1'b0; applyStimulus(6);

    $display("[TB] bit independence");
    cur_en = '1; cur_pre = 0; cur_thr = 1; cur_raw = 32'h8000_0000; applyStimulus(8);
    cur_raw = 32'h0000_0001; applyStimulus(8);

    $display("[TB] randomized");
    for (int r = 0; r < 400; r++) begin
      cur_rst = ($urandom_range(0, 60) == 0);
      cur_raw = cur_raw ^ ($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) cur_en = $urandom;
      if ($urandom_range(0, 20) == 0) cur_pre = $urandom_range(0, 5);
      if ($urandom_range(0, 20) == 0) cur_thr = $urandom_range(0, 4);
      applyStimulus($urandom_range(1, 6));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Per-pin input conditioning stage that sits directly upstream of the GPIO register block's input path.
- Takes raw pad inputs, synchronises them into the clock domain and optionally debounces each bit with a shared prescaled tick.
- Produces clean levels, plus single-cycle rise and fall pulses, for the interrupt and edge-capture logic to consume.

Parameters:
- NUM_BITS, 32, number of GPIO pins handled.
- CNT_WIDTH, 8, width of each per-bit stability counter; bounds the maximum threshold.
- PRE_WIDTH, 16, width of the shared tick prescaler.

Ports:
- clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- gpio_raw  input  NUM_BITS  asynchronous pad inputs.
- deb_en  input  NUM_BITS  per-bit debounce enable; 0 = bypass (sync only).
- prescale  input  PRE_WIDTH  tick period minus 1, in clk cycles.
- threshold  input  CNT_WIDTH  consecutive stable ticks required to accept a new level.
- gpio_sync  output  NUM_BITS  2-FF synchronised raw level.
- gpio_filt  output  NUM_BITS  conditioned level; feeds the register block's gpio_i.
- rise  output  NUM_BITS  one-cycle pulse on a 0->1 change of gpio_filt.
- fall  output  NUM_BITS  one-cycle pulse on a 1->0 change of gpio_filt.
- tick  output  1  one-cycle prescaler strobe (observability).

Behaviour:
- Reset: all flops clear on any clk edge with reset=1. This includes the sync stages, gpio_filt, filt_prev, the per-bit counters and the prescaler. All outputs read 0 the cycle after reset. Reset asserted mid-count discards all progress.
- Synchroniser:
  - Two flop stages per bit; gpio_sync is the second stage.
  - Raw-to-gpio_sync latency is 2 cycles.
  - No reset-released glitch: both stages reset to 0.
- Prescaler:
  - pre_cnt counts up each cycle.
  - When pre_cnt >= prescale: tick=1 and pre_cnt<=0; otherwise tick=0.
  - prescale=0 gives tick on every cycle.
  - Using >= means a mid-count reduction of prescale wraps on the next cycle, with no long stall.
  - Free-running, independent of deb_en.
- Bypass (deb_en[b]=0):
  - gpio_filt[b] <= gpio_sync[b] every cycle; raw-to-filt latency is 3 cycles.
  - cnt[b] held at 0.
- Debounce (deb_en[b]=1):
  - If gpio_sync[b]==gpio_filt[b]: cnt[b]<=0 on that cycle, regardless of tick.
  - Else, on tick:
    - If cnt[b]+1 >= eff_thr: gpio_filt[b]<=gpio_sync[b] and cnt[b]<=0.
    - Otherwise cnt[b]<=cnt[b]+1.
  - Else, with no tick: cnt[b] holds.
  - eff_thr = (threshold==0) ? 1 : threshold. threshold 0 and 1 therefore behave identically: accept on the first tick of mismatch.
  - Any bounce back to the filtered level before acceptance restarts the count from 0.
  - Counter never exceeds eff_thr-1, so no overflow/wrap is possible.
- Toggling deb_en mid-count:
  - 1->0: bypass takes effect next cycle and cnt clears.
  - 0->1: counting starts from 0.
- Edges:
  - filt_prev <= gpio_filt each cycle.
  - rise = gpio_filt & ~filt_prev; fall = ~gpio_filt & filt_prev.
  - Each pulse is exactly 1 cycle, coincident with the first cycle of the new gpio_filt value.
  - rise and fall never assert together for the same bit.
- All bits are independent; there is no cross-bit interaction except the shared tick.

Test Plan:
- Reset/idle: hold reset 3 cycles with gpio_raw=all-ones -> all outputs 0 during reset. After release, bypass (deb_en=0): gpio_filt=all-ones 3 cycles later; rise=all-ones for exactly 1 cycle, fall=0.
- Debounce accept: deb_en[0]=1, prescale=3, threshold=4; gpio_raw[0] 0->1 held -> tick every 4 cycles. gpio_filt[0] rises on the 4th tick after gpio_sync[0] changes; rise[0] pulses once.
- Bounce reject: same config; gpio_raw[0] high for 10 cycles, low for 2, high for 10 -> gpio_filt[0] stays 0 and rise[0] stays 0; counter restarts after the low glitch.
- Threshold 0 vs 1 and prescale 0: threshold=0, prescale=0, deb_en=1, toggle gpio_raw[5] -> gpio_filt[5] follows after 2+1 cycles. Repeat with threshold=1 -> identical trace.
- Mid-op changes: during a count, reduce prescale from 100 to 2 -> tick on the next cycle. Then clear deb_en[3] mid-count -> gpio_filt[3] equals gpio_sync[3] next cycle. Assert reset mid-count -> all state 0.
- Independence: bits 0 and 31 toggled in opposite directions on the same cycle with deb_en=all-ones -> rise[0] and fall[31] assert on the same cycle; no other bits change.
